// File: rtl/latch_write_sched_pkg.sv
// Shared state encoding and default sizing for the latch write scheduler.
package latch_write_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NWORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/latch_write_sched_rr_arbiter.sv
// Round-robin requester selection: first active request at or after pointer, wrapping.
module rr_arbiter
    import latch_write_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] pointer,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] index
);

    localparam int IW = $clog2(NREQ);

    logic          found;
    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // NREQ is a power of two, so the IW-bit sum wraps from NREQ-1 to 0.
            cand = pointer + IW'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/latch_write_sched.sv
// Sequences one write at a time into an external D-latch bank:
// select -> set up data -> open one latch for a cycle -> hold and acknowledge.
module latch_write_sched
    import latch_write_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int NWORD = DEF_NWORD
) (
    input  logic                             clock,
    input  logic                             reset_bar,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ*$clog2(NWORD)-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0]            req_data,
    output logic [NREQ-1:0]                  gnt,
    output logic [NWORD-1:0]                 latch_en,
    output logic [WIDTH-1:0]                 latch_d,
    output logic                             busy
);

    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(NWORD);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    arb_idx;
    logic [NREQ-1:0]  arb_grant;
    logic [NREQ-1:0]  win_oh;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;
    logic [NWORD-1:0] latch_en_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             take;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .pointer (ptr),
        .grant   (arb_grant),
        .index   (arb_idx)
    );

    assign take = (state == IDLE) && (|req);

    always_comb begin
        state_nxt    = state;
        latch_en_nxt = '0;
        gnt_nxt      = '0;
        case (state)
            IDLE:  if (|req) state_nxt = SETUP;
            SETUP: begin
                state_nxt            = OPEN;
                latch_en_nxt[addr_q] = 1'b1;
            end
            OPEN: begin
                state_nxt = HOLD;
                gnt_nxt   = win_oh;
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: data_q is reset too because it drives latch_d straight to the bank; enables and grants come from flops so they cannot glitch.
    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state    <= IDLE;
            ptr      <= '0;
            win_oh   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            latch_en <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_nxt;
            latch_en <= latch_en_nxt;
            gnt      <= gnt_nxt;
            // Requester inputs are looked at only here; later changes cannot disturb the sequence.
            if (take) begin
                ptr    <= arb_idx + IW'(1);
                win_oh <= arb_grant;
                addr_q <= req_addr[int'(arb_idx)*AW +: AW];
                data_q <= req_data[int'(arb_idx)*WIDTH +: WIDTH];
            end
        end
    end

    assign latch_d = data_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_latch_write_sched.sv
// Randomized and directed bench for latch_write_sched against a timestamped transaction model.
module tb_latch_write_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int NWORD = 4;
    localparam int AW    = 2;

    logic                  clock = 1'b0;
    logic                  reset_bar = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*AW-1:0]    req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       gnt;
    logic [NWORD-1:0]      latch_en;
    logic [WIDTH-1:0]      latch_d;
    logic                  busy;

    latch_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .NWORD(NWORD)) dut (
        .clock     (clock),
        .reset_bar (reset_bar),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .latch_en  (latch_en),
        .latch_d   (latch_d),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Behavioural stand-in for the bank of transparent-high d_latch cells.
    logic [WIDTH-1:0] bank [NWORD];
    always @(latch_en or latch_d) begin
        for (int w = 0; w < NWORD; w++)
            if (latch_en[w]) bank[w] = latch_d;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each accepted write is a timestamp plus its winner/address/data.
    int               cyc   = 0;
    int               start = -100;
    int               ptr   = 0;
    int               win   = 0;
    int               waddr = 0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] exp_d = '0;
    logic [NREQ*AW-1:0]    a_pk = '0;
    logic [NREQ*WIDTH-1:0] d_pk = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic cycle_check();
        int               ph;
        logic [NWORD-1:0] e_en;
        logic [NREQ-1:0]  e_gnt;
        ph    = cyc - start;
        e_en  = '0;
        e_gnt = '0;
        if (ph == 1) exp_d = wdata;
        if (ph == 2) e_en[waddr] = 1'b1;
        if (ph == 3) e_gnt[win] = 1'b1;
        check("latch_en", 32'(latch_en), 32'(e_en));
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("busy",     32'(busy),     32'(ph >= 1 && ph <= 3));
        check("latch_d",  32'(latch_d),  32'(exp_d));
        if (ph == 3) check("bank_word", 32'(bank[waddr]), 32'(wdata));
    endtask

    // Check the cycle now running, then present new inputs and let the model decide on a selection.
    task automatic apply(input logic [NREQ-1:0] r);
        @(negedge clock);
        cycle_check();
        req      = r;
        req_addr = a_pk;
        req_data = d_pk;
        if ((cyc - start) >= 4 && r != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ptr + k) % NREQ;
                if (r[j]) begin
                    win   = j;
                    waddr = int'(a_pk[j*AW +: AW]);
                    wdata = d_pk[j*WIDTH +: WIDTH];
                    ptr   = (j + 1) % NREQ;
                    start = cyc;
                    break;
                end
            end
        end
        cyc++;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_latch_en"}, 32'(latch_en), 32'h0);
        check({tag, "_gnt"},      32'(gnt),      32'h0);
        check({tag, "_busy"},     32'(busy),     32'h0);
        check({tag, "_latch_d"},  32'(latch_d),  32'h0);
    endtask

    initial begin
        #1;
        reset_checks("por");
        repeat (2) @(negedge clock);
        reset_bar = 1'b1;

        // Everyone requesting: grants rotate 0,1,2,3 one every four cycles.
        a_pk = {2'd3, 2'd2, 2'd1, 2'd0};
        d_pk = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (16) apply(4'b1111);

        // Wrap: last winner was 3, so 0 comes before 3.
        repeat (8) apply(4'b1001);
        repeat (2) apply(4'b0000);

        // Single write of A5 to word 2 from requester 0.
        a_pk = {2'd0, 2'd0, 2'd0, 2'd2};
        d_pk = {8'h00, 8'h00, 8'h00, 8'hA5};
        apply(4'b0001);
        repeat (5) apply(4'b0000);

        // Data changes after selection must not reach the latch; the held req then re-requests.
        a_pk = {2'd0, 2'd0, 2'd0, 2'd1};
        d_pk = {8'h00, 8'h00, 8'h00, 8'h3C};
        apply(4'b0001);
        d_pk = {8'h00, 8'h00, 8'h00, 8'hFF};
        repeat (7) apply(4'b0001);
        repeat (2) apply(4'b0000);

        // Reset while a latch is open.
        a_pk = {2'd0, 2'd3, 2'd0, 2'd0};
        d_pk = {8'h00, 8'h5A, 8'h00, 8'h00};
        apply(4'b0100);
        repeat (2) apply(4'b0000);
        #1;
        check("pre_reset_open", 32'(latch_en), 32'(4'b1000));
        reset_bar = 1'b0;
        #1;
        reset_checks("mid_open");
        repeat (2) @(negedge clock);
        reset_checks("held");
        reset_bar = 1'b1;
        start = -100;
        ptr   = 0;
        exp_d = '0;
        // After release the pointer is back at requester 0.
        a_pk = {2'd0, 2'd1, 2'd2, 2'd3};
        d_pk = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        repeat (4) apply(4'b1111);

        // Idle stretch.
        repeat (10) apply(4'b0000);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [NREQ-1:0] r;
            r    = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            a_pk = (NREQ*AW)'($urandom);
            d_pk = $urandom;
            apply(r);
        end
        repeat (6) apply(4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
